// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared widths, size encodings, FSM states and the alignment check for the lsu
package lsu_pkg;

  localparam int RESULT_W   = 64;
  localparam int LREG_W     = 5;
  localparam int MEM_MASK_W = 8;

  // One-hot access size encodings.
  localparam logic [3:0] LS_SIZE_B = 4'b0001;
  localparam logic [3:0] LS_SIZE_H = 4'b0010;
  localparam logic [3:0] LS_SIZE_W = 4'b0100;
  localparam logic [3:0] LS_SIZE_D = 4'b1000;

  typedef logic [1:0] lsu_state_t;
  localparam lsu_state_t LSU_IDLE = 2'd0;
  localparam lsu_state_t LSU_REQ  = 2'd1;
  localparam lsu_state_t LSU_RESP = 2'd2;
  localparam lsu_state_t LSU_WB   = 2'd3;

  // High when the size is not one-hot or the offset is not a multiple of the size.
  function automatic logic access_bad(input logic [3:0] size, input logic [2:0] off);
    logic bad;
    case (size)
      LS_SIZE_B: bad = 1'b0;
      LS_SIZE_H: bad = off[0];
      LS_SIZE_W: bad = |off[1:0];
      LS_SIZE_D: bad = |off;
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - combinational byte-lane shift for stores and extract/extend for loads
// Ports: off (byte offset in doubleword), size (one-hot), is_unsigned,
//        store_data -> wmask/wdata, resp_data -> load_data.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]            off,
  input  logic [3:0]            size,
  input  logic                  is_unsigned,
  input  logic [RESULT_W-1:0]   store_data,
  input  logic [RESULT_W-1:0]   resp_data,
  output logic [MEM_MASK_W-1:0] wmask,
  output logic [RESULT_W-1:0]   wdata,
  output logic [RESULT_W-1:0]   load_data
);

  logic [MEM_MASK_W-1:0] base_mask;
  logic [RESULT_W-1:0]   shifted;

  always_comb begin
    case (size)
      LS_SIZE_B: base_mask = 8'h01;
      LS_SIZE_H: base_mask = 8'h03;
      LS_SIZE_W: base_mask = 8'h0F;
      LS_SIZE_D: base_mask = 8'hFF;
      default:   base_mask = 8'h00;
    endcase
    wmask   = base_mask << off;
    wdata   = store_data << {off, 3'b000};
    shifted = resp_data >> {off, 3'b000};

    case (size)
      LS_SIZE_B: load_data = is_unsigned ? {56'd0, shifted[7:0]}
                                         : {{56{shifted[7]}}, shifted[7:0]};
      LS_SIZE_H: load_data = is_unsigned ? {48'd0, shifted[15:0]}
                                         : {{48{shifted[15]}}, shifted[15:0]};
      LS_SIZE_W: load_data = is_unsigned ? {32'd0, shifted[31:0]}
                                         : {{32{shifted[31]}}, shifted[31:0]};
      LS_SIZE_D: load_data = shifted;
      default:   load_data = '0;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - single-outstanding load/store unit between the AGU and the data-memory port
// Ports: clock/reset; req_* op from execute (address, type, size, store data, rd);
//        flush redirect; mem_req_* request and mem_resp_* response to memory;
//        wb_* load writeback; misalign_exc one-cycle exception pulse.
module lsu
  import lsu_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [RESULT_W-1:0]   ls_address,
  input  logic                  is_load,
  input  logic                  is_store,
  input  logic                  is_unsigned,
  input  logic [3:0]            ls_size,
  input  logic [RESULT_W-1:0]   store_data,
  input  logic [LREG_W-1:0]     rd,
  input  logic                  flush,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [RESULT_W-1:0]   mem_req_addr,
  output logic                  mem_req_wen,
  output logic [MEM_MASK_W-1:0] mem_req_wmask,
  output logic [RESULT_W-1:0]   mem_req_wdata,
  input  logic                  mem_resp_valid,
  input  logic [RESULT_W-1:0]   mem_resp_data,
  output logic                  wb_valid,
  output logic [LREG_W-1:0]     wb_rd,
  output logic [RESULT_W-1:0]   wb_data,
  output logic                  misalign_exc
);

  lsu_state_t            state_q;
  logic [RESULT_W-1:0]   addr_q;
  logic [RESULT_W-1:0]   data_q;
  logic [3:0]            size_q;
  logic                  is_load_q;
  logic                  is_store_q;
  logic                  is_unsigned_q;
  logic [LREG_W-1:0]     rd_q;
  logic                  drop_q;
  logic [RESULT_W-1:0]   wb_data_q;
  logic                  misalign_q;
  logic [RESULT_W-1:0]   load_data;

  lsu_align u_align (
    .off         (addr_q[2:0]),
    .size        (size_q),
    .is_unsigned (is_unsigned_q),
    .store_data  (data_q),
    .resp_data   (mem_resp_data),
    .wmask       (mem_req_wmask),
    .wdata       (mem_req_wdata),
    .load_data   (load_data)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= LSU_IDLE;
      addr_q        <= '0;
      data_q        <= '0;
      size_q        <= '0;
      is_load_q     <= 1'b0;
      is_store_q    <= 1'b0;
      is_unsigned_q <= 1'b0;
      rd_q          <= '0;
      drop_q        <= 1'b0;
      wb_data_q     <= '0;
      misalign_q    <= 1'b0;
    end else begin
      misalign_q <= 1'b0;
      case (state_q)
        LSU_IDLE: begin
          if (req_valid && !flush) begin
            addr_q        <= ls_address;
            data_q        <= store_data;
            size_q        <= ls_size;
            is_load_q     <= is_load;
            is_store_q    <= is_store;
            is_unsigned_q <= is_unsigned;
            rd_q          <= rd;
            drop_q        <= 1'b0;
            if (access_bad(ls_size, ls_address[2:0])) begin
              misalign_q <= 1'b1;
            end else begin
              state_q <= LSU_REQ;
            end
          end
        end
        LSU_REQ: begin
          // A handshake in the same cycle as a flush still issues the request,
          // so its response must be consumed and discarded.
          if (mem_req_ready) begin
            state_q <= LSU_RESP;
            drop_q  <= flush;
          end else if (flush) begin
            state_q <= LSU_IDLE;
          end
        end
        LSU_RESP: begin
          if (flush) begin
            drop_q <= 1'b1;
          end
          if (mem_resp_valid) begin
            if (is_load_q && !drop_q && !flush) begin
              wb_data_q <= load_data;
              state_q   <= LSU_WB;
            end else begin
              state_q <= LSU_IDLE;
            end
          end
        end
        LSU_WB:  state_q <= LSU_IDLE;
        default: state_q <= LSU_IDLE;
      endcase
    end
  end

  assign req_ready     = (state_q == LSU_IDLE);
  assign mem_req_valid = (state_q == LSU_REQ);
  assign mem_req_addr  = {addr_q[RESULT_W-1:3], 3'b000};
  assign mem_req_wen   = is_store_q;
  assign wb_valid      = (state_q == LSU_WB) && !flush;
  assign wb_rd         = rd_q;
  assign wb_data       = wb_data_q;
  assign misalign_exc  = misalign_q;

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - randomized self-checking bench for lsu against a byte-level reference model
module tb_lsu;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] ls_address;
  logic        is_load;
  logic        is_store;
  logic        is_unsigned;
  logic [3:0]  ls_size;
  logic [63:0] store_data;
  logic [4:0]  rd;
  logic        flush;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_req_addr;
  logic        mem_req_wen;
  logic [7:0]  mem_req_wmask;
  logic [63:0] mem_req_wdata;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_data;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        misalign_exc;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  lsu dut (
    .clock          (clock),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .ls_address     (ls_address),
    .is_load        (is_load),
    .is_store       (is_store),
    .is_unsigned    (is_unsigned),
    .ls_size        (ls_size),
    .store_data     (store_data),
    .rd             (rd),
    .flush          (flush),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wen    (mem_req_wen),
    .mem_req_wmask  (mem_req_wmask),
    .mem_req_wdata  (mem_req_wdata),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .wb_valid       (wb_valid),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data),
    .misalign_exc   (misalign_exc)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int size_bytes(input logic [3:0] size);
    case (size)
      4'b0001: return 1;
      4'b0010: return 2;
      4'b0100: return 4;
      4'b1000: return 8;
      default: return 0;
    endcase
  endfunction

  // Reference: pick bytes out of the response, then extend.
  function automatic logic [63:0] model_load(input logic [63:0] rdata, input int off,
                                             input int nb, input bit uns);
    logic [63:0] v = '0;
    for (int i = 0; i < nb; i++) v[8*i +: 8] = rdata[8*(off+i) +: 8];
    if (!uns && nb < 8 && v[8*nb-1])
      for (int i = nb; i < 8; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  task automatic idle_inputs();
    req_valid = 0; is_load = 0; is_store = 0; is_unsigned = 0;
    ls_size = 0; ls_address = 0; store_data = 0; rd = 0;
  endtask

  // Drives one op end to end; all sampling happens at negedge.
  task automatic do_op(input logic [63:0] addr, input bit ld, input bit uns,
                       input logic [3:0] size, input logic [63:0] sdata,
                       input logic [4:0] rdv, input int rdly, input int pdly,
                       input logic [63:0] rdata);
    int nb, off;
    bit bad;
    logic [15:0] m;
    nb  = size_bytes(size);
    off = int'(addr[2:0]);
    bad = (nb == 0) || ((addr % 64'(nb)) != 0);
    check("accept_ready", req_ready, 1);
    req_valid = 1; ls_address = addr; is_load = ld; is_store = !ld;
    is_unsigned = uns; ls_size = size; store_data = sdata; rd = rdv;
    @(negedge clock);
    idle_inputs();
    if (bad) begin
      check("misalign_pulse", misalign_exc, 1);
      check("misalign_noreq", mem_req_valid, 0);
      check("misalign_ready", req_ready, 1);
      return;
    end
    m = ((16'd1 << nb) - 16'd1) << off;
    check("no_exc", misalign_exc, 0);
    check("busy", req_ready, 0);
    for (int c = 0; c <= rdly; c++) begin
      check("req_valid", mem_req_valid, 1);
      check("req_addr", mem_req_addr, addr & ~64'h7);
      check("req_wen", mem_req_wen, !ld);
      check("req_wmask", mem_req_wmask, m[7:0]);
      if (!ld) check("req_wdata", mem_req_wdata, sdata << (8*off));
      if (c == rdly) mem_req_ready = 1;
      @(negedge clock);
      mem_req_ready = 0;
    end
    for (int c = 0; c <= pdly; c++) begin
      check("resp_wait_noreq", mem_req_valid, 0);
      check("resp_wait_nowb", wb_valid, 0);
      if (c == pdly) begin mem_resp_valid = 1; mem_resp_data = rdata; end
      @(negedge clock);
      mem_resp_valid = 0; mem_resp_data = 0;
    end
    if (ld) begin
      check("wb_valid", wb_valid, 1);
      check("wb_rd", wb_rd, rdv);
      check("wb_data", wb_data, model_load(rdata, off, nb, uns));
      check("wb_busy", req_ready, 0);
      @(negedge clock);
    end
    check("after_nowb", wb_valid, 0);
    check("after_ready", req_ready, 1);
  endtask

  initial begin
    logic [63:0] a;
    logic [3:0] sz;
    logic [3:0] bad_sizes [4];
    bad_sizes[0] = 4'b0000; bad_sizes[1] = 4'b0011;
    bad_sizes[2] = 4'b1100; bad_sizes[3] = 4'b1111;
    idle_inputs();
    flush = 0; mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = 0;
    reset = 1;
    @(negedge clock); @(negedge clock);
    check("rst_ready", req_ready, 1);
    check("rst_reqv", mem_req_valid, 0);
    check("rst_wbv", wb_valid, 0);
    check("rst_exc", misalign_exc, 0);
    check("rst_wbdata", wb_data, 0);
    check("rst_addr", mem_req_addr, 0);
    reset = 0;
    @(negedge clock);

    // Directed cases.
    do_op(64'h1003, 1, 0, 4'b0001, 0, 5'd7, 0, 0, 64'h00000000_80FF0000);
    do_op(64'h2006, 1, 1, 4'b0010, 0, 5'd9, 0, 0, 64'hBEEF_0000_0000_0000);
    do_op(64'h3004, 0, 0, 4'b0100, 64'h12345678, 5'd3, 3, 1, 64'h0);
    do_op(64'h4002, 1, 0, 4'b0100, 0, 5'd4, 0, 0, 64'h0);
    do_op(64'h4008, 1, 0, 4'b1000, 0, 5'd5, 0, 0, 64'h8123_4567_89AB_CDEF);
    check("exc_cleared", misalign_exc, 0);

    // Flush while waiting for the response.
    req_valid = 1; ls_address = 64'h5000; is_load = 1; ls_size = 4'b1000; rd = 5'd11;
    @(negedge clock);
    idle_inputs();
    mem_req_ready = 1;
    @(negedge clock);
    mem_req_ready = 0;
    flush = 1;
    @(negedge clock);
    flush = 0;
    @(negedge clock);
    mem_resp_valid = 1; mem_resp_data = 64'hDEAD;
    @(negedge clock);
    mem_resp_valid = 0;
    check("flush_nowb", wb_valid, 0);
    check("flush_ready", req_ready, 1);
    @(negedge clock);
    check("flush_nowb2", wb_valid, 0);

    // Flush together with req_valid: not accepted.
    req_valid = 1; ls_address = 64'h6000; is_load = 1; ls_size = 4'b0001; flush = 1;
    @(negedge clock);
    idle_inputs(); flush = 0;
    check("flush_acc_ready", req_ready, 1);
    check("flush_acc_noreq", mem_req_valid, 0);

    // Reset while a request is pending.
    req_valid = 1; ls_address = 64'h7010; is_store = 1; ls_size = 4'b0100;
    store_data = 64'hCAFE; rd = 5'd2;
    @(negedge clock);
    idle_inputs();
    check("pre_rst_reqv", mem_req_valid, 1);
    reset = 1;
    @(negedge clock);
    reset = 0;
    check("mrst_reqv", mem_req_valid, 0);
    check("mrst_ready", req_ready, 1);
    check("mrst_wbv", wb_valid, 0);
    check("mrst_addr", mem_req_addr, 0);
    check("mrst_wmask", mem_req_wmask, 0);
    check("mrst_wdata", mem_req_wdata, 0);
    check("mrst_wen", mem_req_wen, 0);
    @(negedge clock);

    // Random ops.
    for (int n = 0; n < 60; n++) begin
      a = {$urandom, $urandom};
      if ($urandom_range(9) == 0) sz = bad_sizes[$urandom_range(3)];
      else sz = 4'b0001 << $urandom_range(3);
      if ($urandom_range(1) == 1 && size_bytes(sz) != 0)
        a = a & ~(64'(size_bytes(sz)) - 64'd1);
      do_op(a, 1'($urandom_range(1)), 1'($urandom_range(1)), sz, {$urandom, $urandom},
            5'($urandom), int'($urandom_range(3)), int'($urandom_range(3)),
            {$urandom, $urandom});
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
